// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_arb_pkg
// Description : Shared encodings and helpers for the writeback arbiter:
//               source indices, output-stage states and the grant-counter
//               width.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_arb_pkg;

    // Number of requesters sharing the writeback mux
    localparam int NREQ = 3;

    // Width of each saturating grant counter
    localparam int GCNT_W = 16;

    // Source index type and encodings (also the mux address)
    typedef logic [1:0] src_t;
    localparam src_t SRC_IN0 = 2'b00;
    localparam src_t SRC_IN1 = 2'b01;
    localparam src_t SRC_IN2 = 2'b10;

    // Output-stage state encodings
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    // Next index in the circular order 0 -> 1 -> 2 -> 0
    function automatic src_t rr_next(input src_t idx);
        src_t nxt;
        case (idx)
            SRC_IN0: nxt = SRC_IN1;
            SRC_IN1: nxt = SRC_IN2;
            default: nxt = SRC_IN0;
        endcase
        return nxt;
    endfunction

    // One-hot grant vector for a source index
    function automatic logic [NREQ-1:0] src_onehot(input src_t idx);
        logic [NREQ-1:0] vec;
        case (idx)
            SRC_IN0: vec = 3'b001;
            SRC_IN1: vec = 3'b010;
            SRC_IN2: vec = 3'b100;
            default: vec = 3'b000;
        endcase
        return vec;
    endfunction

endpackage : wb_arb_pkg
`default_nettype wire

// File: rtl/mux3to1.sv
`default_nettype none
// ============================================================================
// Module      : mux3to1
// Description : 3:1 word multiplexer for the writeback result path. The
//               unused address 2'b11 yields zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mux3to1
    import wb_arb_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [1:0]   address,
    output logic [W-1:0] out
);

    // Pure combinational select on the address
    always_comb begin
        out = '0;
        case (address)
            SRC_IN0: out = in0;
            SRC_IN1: out = in1;
            SRC_IN2: out = in2;
            default: out = '0;
        endcase
    end

endmodule : mux3to1
`default_nettype wire

// File: rtl/wb_arbiter3.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter3
// Description : Round-robin arbiter for three writeback requesters (ALU,
//               memory, PC+4 link) with a single-entry registered output
//               stage toward the register-file write port. Drives the
//               address of the shared mux3to1.
//               Optional feature macro: WB_ARB_STATS_EN adds three 16-bit
//               saturating grant counters on grant_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter3
    import wb_arb_pkg::*;
#(
    parameter int W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       in_valid,
    output logic [NREQ-1:0]       in_ready,
    input  logic [W-1:0]          in0,
    input  logic [W-1:0]          in1,
    input  logic [W-1:0]          in2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W-1:0]          out_data,
    output logic [1:0]            out_src
`ifdef WB_ARB_STATS_EN
    ,
    output logic [NREQ*GCNT_W-1:0] grant_cnt
`endif
);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [0:0]   r_state;
    logic [W-1:0] r_data;
    src_t         r_src;
    src_t         r_last;   // last granted index; reset 2 gives in0 first turn
    src_t         r_addr;   // mux address remembered while idle

    // ------------------------------------------------------------------
    // Combinational arbitration
    // ------------------------------------------------------------------
    logic         w_can_load;
    logic [3:0]   w_valid_ext;
    src_t         w_p0;
    src_t         w_p1;
    src_t         w_p2;
    logic         w_gnt_vld;
    src_t         w_gnt_idx;
    src_t         w_addr;
    logic [W-1:0] w_mux_out;

    // The output register can take a word when empty or being drained now
    assign w_can_load = (r_state == ST_EMPTY) | out_ready;

    // Pad to four bits so a 2-bit index always selects in range
    assign w_valid_ext = {1'b0, in_valid};

    // Priority order starts just after the last winner
    assign w_p0 = rr_next(r_last);
    assign w_p1 = rr_next(w_p0);
    assign w_p2 = rr_next(w_p1);

    // Pick the first valid requester in rotating priority order
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = SRC_IN0;
        if (w_can_load) begin
            if (w_valid_ext[w_p0]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_p0;
            end else if (w_valid_ext[w_p1]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_p1;
            end else if (w_valid_ext[w_p2]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_p2;
            end
        end
    end

    // A grant only goes to a valid requester, so a grant is an accept.
    // in_ready depends only on in_valid, out_ready and state, never on data.
    assign in_ready = w_gnt_vld ? src_onehot(w_gnt_idx) : {NREQ{1'b0}};

    // Hold the previous address when idle so the mux output stays quiet
    assign w_addr = w_gnt_vld ? w_gnt_idx : r_addr;

    // ------------------------------------------------------------------
    // Shared result mux
    // ------------------------------------------------------------------
    mux3to1 #(
        .W       (W)
    ) u_mux (
        .in0     (in0),
        .in1     (in1),
        .in2     (in2),
        .address (w_addr),
        .out     (w_mux_out)
    );

    // Output stage: load on accept, drain to EMPTY when consumed with no refill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_data  <= '0;
            r_src   <= SRC_IN0;
            r_last  <= SRC_IN2;
            r_addr  <= SRC_IN0;
        end else if (w_gnt_vld) begin
            r_state <= ST_FULL;
            r_data  <= w_mux_out;
            r_src   <= w_gnt_idx;
            r_last  <= w_gnt_idx;
            r_addr  <= w_gnt_idx;
        end else if (out_ready) begin
            r_state <= ST_EMPTY;
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign out_data  = r_data;
    assign out_src   = r_src;

`ifdef WB_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Per-requester saturating grant counters
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt
        logic [GCNT_W-1:0] r_cnt;

        // Count accepts from this requester, sticking at all-ones
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (w_gnt_vld && (w_gnt_idx == src_t'(gi)) && (r_cnt != {GCNT_W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign grant_cnt[gi*GCNT_W +: GCNT_W] = r_cnt;
    end
`endif

endmodule : wb_arbiter3
`default_nettype wire

// File: tb/tb_wb_arbiter3.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter3
// Description : Scoreboard bench for wb_arbiter3. A reference model predicts
//               grants from the rotating-priority rule and queues expected
//               output words; a monitor compares them as the DUT presents
//               them. Stats checks are built with WB_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter3;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   in_valid = 3'b000;
    logic [2:0]   in_ready;
    logic [W-1:0] in0 = '0;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [1:0]   out_src;
`ifdef WB_ARB_STATS_EN
    logic [47:0]  grant_cnt;
`endif

    wb_arbiter3 #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
`ifdef WB_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: rotating priority from the last winner, a one-word
    // output slot, and per-source grant tallies.
    // ------------------------------------------------------------------
    typedef struct {
        logic [W-1:0] d;
        logic [1:0]   s;
    } exp_t;

    exp_t exp_q[$];
    int   m_last = 2;
    bit   m_full = 1'b0;
    int   m_cnt [3] = '{0, 0, 0};

    function automatic int model_grant(input logic [2:0] v, input logic ordy);
        int idx;
        if (m_full && !ordy) return -1;
        for (int k = 1; k <= 3; k++) begin
            idx = (m_last + k) % 3;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [2:0] model_ready(input logic [2:0] v, input logic ordy);
        int g;
        g = model_grant(v, ordy);
        return (g < 0) ? 3'b000 : 3'(1 << g);
    endfunction

    // Asynchronous reset empties the model immediately
    always @(negedge rst_n) begin
        exp_q.delete();
        m_last = 2;
        m_full = 1'b0;
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    end

    // Predictor: at each active edge decide what the DUT accepts
    always @(posedge clk) begin
        int g;
        exp_t e;
        if (rst_n === 1'b1) begin
            g = model_grant(in_valid, out_ready);
            if (g >= 0) begin
                e.d = (g == 0) ? in0 : (g == 1) ? in1 : in2;
                e.s = 2'(g);
                exp_q.push_back(e);
                m_last = g;
                m_full = 1'b1;
                if (m_cnt[g] < 65535) m_cnt[g]++;
            end else if (out_ready) begin
                m_full = 1'b0;
            end
        end
    end

    // Monitor: mid-cycle, check grant and the presented word
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("in_ready", {61'd0, in_ready}, {61'd0, model_ready(in_valid, out_ready)});
            chk("out_valid", {63'd0, out_valid}, {63'd0, m_full});
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 64'd1, 64'd0);
                end else begin
                    chk("out_data", {32'd0, out_data}, {32'd0, exp_q[0].d});
                    chk("out_src", {62'd0, out_src}, {62'd0, exp_q[0].s});
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [2:0]   pend;
    logic [2:0]   acc;
    logic [W-1:0] pd [3];

    initial begin
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_out_src", {62'd0, out_src}, 64'd0);
        chk("rst_in_ready", {61'd0, in_ready}, 64'd0);
        step();
        step();

        // Reset priority and round-robin
        in0 = 126; in1 = 53; in2 = 178;
        in_valid = 3'b111; out_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        chk("first_grant", {61'd0, in_ready}, 64'b001);
        step();
        chk("rr0_data", {32'd0, out_data}, 64'd126);
        chk("rr0_src", {62'd0, out_src}, 64'd0);
        step();
        chk("rr1_data", {32'd0, out_data}, 64'd53);
        chk("rr1_src", {62'd0, out_src}, 64'd1);
        step();
        chk("rr2_data", {32'd0, out_data}, 64'd178);
        chk("rr2_src", {62'd0, out_src}, 64'd2);
        step();
        chk("rr3_data", {32'd0, out_data}, 64'd126);
        chk("rr3_src", {62'd0, out_src}, 64'd0);

        // Back-pressure: drain, load 97 from in1, then stall
        in_valid = 3'b000;
        step();
        in1 = 97; in_valid = 3'b010; out_ready = 1'b0;
        step();
        in_valid = 3'b100; in2 = 28;
        for (int c = 0; c < 3; c++) begin
            chk("bp_data", {32'd0, out_data}, 64'd97);
            chk("bp_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_ready", {61'd0, in_ready}, 64'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("bp_release_data", {32'd0, out_data}, 64'd28);
        chk("bp_release_src", {62'd0, out_src}, 64'd2);

        // Skip idle requesters
        in2 = 14; in_valid = 3'b100;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("skip_src", {62'd0, out_src}, 64'd2);
            chk("skip_data", {32'd0, out_data}, 64'd14);
        end
        in_valid = 3'b000;
        step();

        // Randomized traffic: hold until accepted, occasional withdrawal
        pend = 3'b000;
        for (int i = 0; i < 3; i++) pd[i] = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc = in_valid & in_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (acc[i]) pend[i] = 1'b0;
                else if (pend[i] && $urandom_range(0, 15) == 0) pend[i] = 1'b0;
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    pd[i] = $urandom;
                end
            end
            in_valid  = pend;
            in0 = pd[0]; in1 = pd[1]; in2 = pd[2];
            out_ready = ($urandom_range(0, 3) != 0);
        end

        // Reset mid-stream while holding 299
        in_valid = 3'b001; in0 = 299; out_ready = 1'b1;
        step();
        while (in_ready != 3'b001 && checks < 1_000_000) step();
        step();
        in_valid = 3'b000; out_ready = 1'b0;
        step();
        chk("hold_299", {32'd0, out_data}, 64'd299);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_data", {32'd0, out_data}, 64'd0);
        in_valid = 3'b111; out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        #1;
        chk("midrst_first_grant", {61'd0, in_ready}, 64'b001);
        step();
        in_valid = 3'b000;
        step();

`ifdef WB_ARB_STATS_EN
        // Grant counters
        in_valid = 3'b000;
        do_reset();
        in0 = 5; in1 = 6; out_ready = 1'b1;
        in_valid = 3'b001;
        repeat (5) step();
        in_valid = 3'b010;
        repeat (2) step();
        in_valid = 3'b000;
        step();
        chk("cnt_5_2", grant_cnt, 64'h0000_0002_0005);
        in_valid = 3'b001;
        repeat (70000) step();
        in_valid = 3'b000;
        step();
        chk("cnt_sat0", {48'd0, grant_cnt[15:0]}, 64'hFFFF);
        chk("cnt_model0", {48'd0, grant_cnt[15:0]}, 64'(m_cnt[0]));
        chk("cnt_model1", {48'd0, grant_cnt[31:16]}, 64'(m_cnt[1]));
        chk("cnt_model2", {48'd0, grant_cnt[47:32]}, 64'(m_cnt[2]));
`endif

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_wb_arbiter3
`default_nettype wire
